// File: rtl/wb_queue_stage.sv
// rtl/wb_queue_stage.sv - in-order writeback queue with load formatting and youngest-match bypass lookup
// Optional PC storage and golden-trace debug ports: define WB_DEBUG_TRACE_EN.
module wb_queue_stage #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       in_rf_we,
    input  logic [AW-1:0]              in_rf_waddr,
    input  logic                       in_sel_mem,
    input  logic [1:0]                 in_mem_size,
    input  logic                       in_mem_signed,
    input  logic [1:0]                 in_byte_off,
    input  logic [DW-1:0]              in_mem_rdata,
    input  logic [DW-1:0]              in_alu_result,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_waddr,
    output logic [DW-1:0]              rf_wdata,
    input  logic                       rf_ack,
    input  logic [AW-1:0]              qry_addr,
    output logic                       qry_hit,
    output logic [DW-1:0]              qry_data,
    output logic [$clog2(DEPTH):0]     occupancy
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [PC_W-1:0]            debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [AW-1:0]              debug_wb_rf_wnum,
    output logic [DW-1:0]              debug_wb_rf_wdata
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [DW-1:0]    q_data  [DEPTH];
    logic [AW-1:0]    q_waddr [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_we;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [OW-1:0]    occ;

    logic             enq;
    logic             deq;
    logic             head_valid;
    logic             head_we;
    logic             enq_we;
    logic [DW-1:0]    enq_data;
    logic [7:0]       fmt_byte;
    logic [15:0]      fmt_half;
    logic [PW-1:0]    scan_idx;

    assign in_ready   = (occ != OW'(DEPTH));
    assign enq        = in_valid & in_ready;
    assign enq_we     = in_rf_we & (in_rf_waddr != '0);
    assign head_valid = q_valid[rd_ptr];
    assign head_we    = q_we[rd_ptr];
    // Non-writing entries retire without waiting on the RF port.
    assign deq        = head_valid & (~head_we | rf_ack);

    assign rf_we      = head_valid & head_we;
    assign rf_waddr   = head_valid ? q_waddr[rd_ptr] : '0;
    assign rf_wdata   = head_valid ? q_data[rd_ptr]  : '0;
    assign occupancy  = occ;

    always_comb begin
        fmt_byte = 8'h00;
        case (in_byte_off)
            2'd0: fmt_byte = in_mem_rdata[7:0];
            2'd1: fmt_byte = in_mem_rdata[15:8];
            2'd2: fmt_byte = in_mem_rdata[23:16];
            2'd3: fmt_byte = in_mem_rdata[31:24];
            default: fmt_byte = 8'h00;
        endcase
        fmt_half = in_byte_off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
        enq_data = in_alu_result;
        if (in_sel_mem) begin
            case (in_mem_size)
                2'b00:   enq_data = {{(DW-8){in_mem_signed & fmt_byte[7]}}, fmt_byte};
                2'b01:   enq_data = {{(DW-16){in_mem_signed & fmt_half[15]}}, fmt_half};
                default: enq_data = in_mem_rdata;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ     <= '0;
            q_valid <= '0;
        end else begin
            if (enq) begin
                q_valid[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (deq) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Payload needs no reset: every read is qualified by q_valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[wr_ptr]  <= enq_data;
            q_waddr[wr_ptr] <= in_rf_waddr;
            q_we[wr_ptr]    <= enq_we;
        end
    end

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        qry_hit  = 1'b0;
        qry_data = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + PW'(k);
            if (q_valid[scan_idx] && q_we[scan_idx] && (q_waddr[scan_idx] == qry_addr)) begin
                qry_hit  = 1'b1;
                qry_data = q_data[scan_idx];
            end
        end
    end

`ifdef WB_DEBUG_TRACE_EN
    logic [PC_W-1:0] q_pc [DEPTH];

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[wr_ptr] <= in_pc;
        end
    end

    assign debug_wb_pc       = head_valid ? q_pc[rd_ptr] : '0;
    assign debug_wb_rf_wen   = {4{rf_we & rf_ack}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    logic unused_pc;
    assign unused_pc = ^in_pc;
`endif

endmodule

// File: tb/tb_wb_queue_stage.sv
// tb/tb_wb_queue_stage.sv - directed self-checking bench for wb_queue_stage
module tb_wb_queue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic        in_sel_mem;
    logic [1:0]  in_mem_size;
    logic        in_mem_signed;
    logic [1:0]  in_byte_off;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ack;
    logic [4:0]  qry_addr;
    logic        qry_hit;
    logic [31:0] qry_data;
    logic [2:0]  occupancy;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    int n_checks = 0;
    int n_errors = 0;

    wb_queue_stage #(.DW(32), .AW(5), .PC_W(32), .DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rf_we      (in_rf_we),
        .in_rf_waddr   (in_rf_waddr),
        .in_sel_mem    (in_sel_mem),
        .in_mem_size   (in_mem_size),
        .in_mem_signed (in_mem_signed),
        .in_byte_off   (in_byte_off),
        .in_mem_rdata  (in_mem_rdata),
        .in_alu_result (in_alu_result),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_ack        (rf_ack),
        .qry_addr      (qry_addr),
        .qry_hit       (qry_hit),
        .qry_data      (qry_data),
        .occupancy     (occupancy)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [4:0] a, input logic we, input logic sel,
                        input logic [1:0] sz, input logic sg, input logic [1:0] off,
                        input logic [31:0] rd, input logic [31:0] alu);
        in_valid      = 1'b1;
        in_rf_waddr   = a;
        in_rf_we      = we;
        in_sel_mem    = sel;
        in_mem_size   = sz;
        in_mem_signed = sg;
        in_byte_off   = off;
        in_mem_rdata  = rd;
        in_alu_result = alu;
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic load_case(input string tag, input logic [1:0] sz, input logic sg,
                             input logic [1:0] off, input logic [31:0] rd, input logic [31:0] exp);
        rf_ack = 1'b0;
        push(5'd7, 1'b1, 1'b1, sz, sg, off, rd, 32'hDEAD0000);
        check({tag, "_we"}, 32'(rf_we), 32'd1);
        check({tag, "_data"}, rf_wdata, exp);
        rf_ack = 1'b1;
        tick();
        rf_ack = 1'b0;
        #1;
        check({tag, "_occ"}, 32'(occupancy), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_rf_we = 1'b0; in_rf_waddr = '0;
        in_sel_mem = 1'b0; in_mem_size = '0; in_mem_signed = 1'b0; in_byte_off = '0;
        in_mem_rdata = '0; in_alu_result = '0; rf_ack = 1'b0; qry_addr = '0;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_qry_hit", 32'(qry_hit), 32'd0);
        check("rst_qry_data", qry_data, 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        reset = 1'b0;
        #1;

        // Load formatting
        load_case("lb_s_off2",  2'b00, 1'b1, 2'd2, 32'h12F45678, 32'hFFFFFFF4);
        load_case("lbu_off2",   2'b00, 1'b0, 2'd2, 32'h12F45678, 32'h000000F4);
        load_case("lh_s_off3",  2'b01, 1'b1, 2'd3, 32'h80001234, 32'hFFFF8000);
        load_case("lhu_off0",   2'b01, 1'b0, 2'd0, 32'h1234ABCD, 32'h0000ABCD);
        load_case("lw_off1",    2'b10, 1'b1, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF);
        load_case("lbu_off3",   2'b00, 1'b0, 2'd3, 32'h9A000000, 32'h0000009A);
        load_case("lb_s_off0",  2'b00, 1'b1, 2'd0, 32'h0000007F, 32'h0000007F);

        // Fill under backpressure, then drain in order
        rf_ack = 1'b0;
        for (int i = 1; i <= 4; i++)
            push(5'(i), 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h100 + 32'(i));
        check("full_occ", 32'(occupancy), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        push(5'd9, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h999);
        check("full_reject_occ", 32'(occupancy), 32'd4);
        rf_ack = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_we", 32'(rf_we), 32'd1);
            check("drain_waddr", 32'(rf_waddr), 32'(i));
            check("drain_wdata", rf_wdata, 32'h100 + 32'(i));
            check("drain_in_ready", 32'(in_ready), (i == 1) ? 32'd0 : 32'd1);
            tick();
        end
        rf_ack = 1'b0;
        #1;
        check("drain_occ", 32'(occupancy), 32'd0);
        check("drain_rf_we", 32'(rf_we), 32'd0);

        // Youngest-match bypass and r0 suppression
        push(5'd6, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h44);
        push(5'd5, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h11);
        push(5'd5, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h22);
        push(5'd0, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h33);
        qry_addr = 5'd5; #1;
        check("byp5_hit", 32'(qry_hit), 32'd1);
        check("byp5_data", qry_data, 32'h22);
        qry_addr = 5'd6; #1;
        check("byp6_data", qry_data, 32'h44);
        qry_addr = 5'd0; #1;
        check("byp0_hit", 32'(qry_hit), 32'd0);
        qry_addr = 5'd9; #1;
        check("byp9_hit", 32'(qry_hit), 32'd0);
        check("byp9_data", qry_data, 32'd0);
        rf_ack = 1'b1;
        qry_addr = 5'd5;
        #1;
        check("bd_head6", 32'(rf_waddr), 32'd6);
        tick();
        check("bd_head5a", rf_wdata, 32'h11);
        check("bd_byp5_after", qry_data, 32'h22);
        tick();
        check("bd_head5b", rf_wdata, 32'h22);
        tick();
        check("bd_r0_no_we", 32'(rf_we), 32'd0);
        check("bd_r0_occ", 32'(occupancy), 32'd1);
        check("bd_byp5_gone", 32'(qry_hit), 32'd0);
        tick();
        check("bd_occ", 32'(occupancy), 32'd0);
        rf_ack = 1'b0;

        // Non-writing entry retires without rf_ack
        push(5'd8, 1'b0, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h55);
        check("nw_occ1", 32'(occupancy), 32'd1);
        check("nw_rf_we", 32'(rf_we), 32'd0);
        tick();
        check("nw_occ0", 32'(occupancy), 32'd0);

        // Reset mid-drain
        push(5'd10, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'hA0);
        push(5'd11, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'hA1);
        push(5'd12, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'hA2);
        qry_addr = 5'd11; #1;
        check("mr_occ3", 32'(occupancy), 32'd3);
        check("mr_hit_pre", 32'(qry_hit), 32'd1);
        reset = 1'b1;
        #1;
        check("mr_occ", 32'(occupancy), 32'd0);
        check("mr_rf_we", 32'(rf_we), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_qry_hit", 32'(qry_hit), 32'd0);
        rf_ack = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("mr_post_rf_we", 32'(rf_we), 32'd0);
        check("mr_post_occ", 32'(occupancy), 32'd0);
        rf_ack = 1'b0;

`ifdef WB_DEBUG_TRACE_EN
        in_pc = 32'h1C000010;
        push(5'd3, 1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'hAB);
        in_pc = '0;
        check("dbg_wen_noack", 32'(debug_wb_rf_wen), 32'd0);
        rf_ack = 1'b1;
        #1;
        check("dbg_pc", debug_wb_pc, 32'h1C000010);
        check("dbg_wen", 32'(debug_wb_rf_wen), 32'hF);
        check("dbg_wnum", 32'(debug_wb_rf_wnum), 32'd3);
        check("dbg_wdata", debug_wb_rf_wdata, 32'hAB);
        tick();
        rf_ack = 1'b0;
        #1;
        check("dbg_pc_empty", debug_wb_pc, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_queue_stage.md
Name: wb_queue_stage

Overview:
- Parametrised successor of the single-entry writeback stage.
- Accepts retiring instructions from MEM over a valid/ready handshake, formats load data, and holds results in a DEPTH-entry in-order queue.
- Drains the queue to a register-file write port that can apply backpressure (rf_ack).
- Exposes a youngest-match bypass lookup over all queued entries for ID/bypass logic.

Parameters:
- DW, 32, data width (must be 32; load formatting assumes 4 byte lanes)
- AW, 5, register address width
- PC_W, 32, PC width (used only with the optional feature)
- DEPTH, 4, queue entries, power of two, >=2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  MEM→WB instruction valid
- in_ready  out  1  queue can accept this cycle
- in_pc  in  PC_W  instruction PC
- in_rf_we  in  1  instruction writes a register
- in_rf_waddr  in  AW  destination register
- in_sel_mem  in  1  1 = write back load data, 0 = ALU result
- in_mem_size  in  2  00 byte, 01 half, 10/11 word
- in_mem_signed  in  1  1 = sign-extend, 0 = zero-extend
- in_byte_off  in  2  address[1:0] of the load
- in_mem_rdata  in  DW  raw data-RAM word
- in_alu_result  in  DW  ALU result
- rf_we  out  1  head entry write request
- rf_waddr  out  AW  head destination
- rf_wdata  out  DW  head data
- rf_ack  in  1  RF accepted the write this cycle
- qry_addr  in  AW  bypass lookup address
- qry_hit  out  1  a queued entry writes qry_addr
- qry_data  out  DW  data of the youngest matching entry
- occupancy  out  log2(DEPTH)+1  entries held

Behaviour:
- Single clock clk. Reset is asynchronous and active-high. On reset, read pointer, write pointer, and occupancy clear to 0, and all entry valid bits clear.
- Reset output values: in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, qry_hit=0, qry_data=0, occupancy=0.
- in_ready = (occupancy != DEPTH), registered-state only; it has no combinational path from rf_ack.
- Enqueue occurs when in_valid & in_ready. The entry stores the formatted data, effective we, waddr, and (optional) pc.
- Effective we = in_rf_we & (in_rf_waddr != 0). Writes to register 0 are never requested and never hit the bypass lookup.
- Load formatting (in_sel_mem=1), applied at enqueue:
  - byte: lane = in_byte_off.
  - half: lane pair = in_byte_off[1]; in_byte_off[0] is ignored.
  - word: raw word; in_byte_off is ignored.
  - Extension follows in_mem_signed.
  - ALU path (in_sel_mem=0) passes in_alu_result unchanged.
- Head outputs are combinational from the head entry:
  - rf_we = head valid & head effective we.
  - rf_waddr and rf_wdata are forced to 0 when the queue is empty.
- Dequeue occurs when the head is valid and either (head effective we & rf_ack) or head effective we=0. Non-writing entries retire one per cycle without the RF port.
- rf_ack while rf_we=0 is ignored.
- Latency: an entry enqueued in cycle N is at the head and drives rf_we in cycle N+1 if the queue was empty. Minimum MEM-to-RF latency is 1 cycle.
- Simultaneous enqueue and dequeue:
  - occupancy is unchanged.
  - When full, in_ready stays 0 that cycle even though a dequeue occurs; the slot frees for the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by occupancy, not by pointer compare.
- Bypass lookup scans all valid entries with effective we=1 and matching waddr. The youngest entry (closest to the write pointer) wins. The lookup is purely combinational and does not include the entry being enqueued this cycle.
- Reset asserted mid-drain discards all entries immediately. No rf_we is issued after the reset edge.

Optional Feature:
- Macro: WB_DEBUG_TRACE_EN.
- When defined, the queue stores PC, and the block adds four outputs for golden-trace comparison:
  - debug_wb_pc [PC_W]
  - debug_wb_rf_wen [4]
  - debug_wb_rf_wnum [AW]
  - debug_wb_rf_wdata [DW]
- The debug outputs are valid in the dequeue cycle only. debug_wb_rf_wen = {4{rf_we & rf_ack}}, and is 0 otherwise. The other debug fields present the head entry; they are 0 on reset and when the queue is empty.
- When undefined, the PC storage and the debug ports do not exist, and in_pc is left unconnected.

Test Plan:
- Reset with 3 entries queued → next cycle occupancy=0, rf_we=0, in_ready=1, qry_hit=0.
- Load byte, signed, off=2, rdata=0x12F45678 → rf_wdata=0xFFFFFFF4. Same load unsigned → 0x000000F4. Half signed, off=3, rdata=0x80001234 → 0xFFFF8000.
- Enqueue 4 writes (r1..r4) with rf_ack held 0 → occupancy=4, in_ready=0. Then rf_ack=1 for 4 cycles → writes r1,r2,r3,r4 in order, one per cycle; in_ready returns 1 the cycle after the first pop.
- Queue holds r5=0x11 (older) and r5=0x22 (younger); qry_addr=5 → qry_hit=1, qry_data=0x22. qry_addr=0 with a queued write to r0 → qry_hit=0, and rf_we never asserts for that entry.
- Non-writing entry (in_rf_we=0) at head with rf_ack=0 → retires in 1 cycle, occupancy decrements, rf_we=0.
- With WB_DEBUG_TRACE_EN defined: PC 0x1C000010 writes r3=0xAB, rf_ack=1 → same cycle debug_wb_pc=0x1C000010, wen=4'hF, wnum=3, wdata=0xAB.
